// File: rtl/inst_loader_pkg.sv
// Shared pipeline and loader types.
// Latency: n/a. Backpressure: n/a.
// Holds the loader FSM encoding and the framing byte counts of a program image.
package inst_loader_pkg;

    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {
        STAGE_IF,
        STAGE_ID,
        STAGE_EX,
        STAGE_WB
    } pipe_stage_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 4;
    localparam int CSUM_BYTES = 1;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Shifts bytes in little-endian order and flags each completed 32-bit word.
// Latency: word and word_done are combinational in the cycle of the 4th byte.
// Backpressure: none; the caller only asserts shift_en on an accepted byte.
module byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output instr_t      word,
    output logic        word_done
);

    logic [31:0] sreg;
    logic [1:0]  cnt;

    // The newest byte lands in the top lane, so after four shifts the first byte sits in 7:0.
    assign word      = {byte_in, sreg[31:8]};
    assign word_done = shift_en && (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (clr) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (shift_en) begin
            sreg <= word;
            cnt  <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Loads a length-prefixed, checksummed program byte stream into instruction memory.
// Latency: one memory write the cycle after each word's 4th byte.
// Backpressure: valid/ready; ready is high in HEADER, PAYLOAD and CHECK.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_WORDS  = 128
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic                  byte_ready_out,
    output logic [ADDR_WIDTH-1:0] mem_addr_out,
    output logic [31:0]           mem_data_out,
    output logic                  mem_we_out,
    output logic                  cpu_rst_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    loader_state_t state, state_nxt;

    logic             xfer;
    logic             start_ok;
    logic             pk_shift;
    logic             pk_done;
    instr_t           pk_word;
    logic             hdr_bad;
    logic             last_word;
    logic [CNT_W-1:0] n_words;
    logic [CNT_W-1:0] word_idx;
    logic [7:0]       csum;

    assign xfer      = byte_valid_in && byte_ready_out;
    assign start_ok  = start_in && (state == IDLE || state == DONE || state == ERROR);
    assign pk_shift  = xfer && (state == HEADER || state == PAYLOAD);
    // The full 32-bit header is range-checked before n_words is truncated to CNT_W.
    assign hdr_bad   = (pk_word == 32'd0) || (pk_word > 32'(MAX_WORDS));
    assign last_word = (word_idx + CNT_W'(1)) == n_words;

    byte_packer u_packer (
        .clk_100mhz (clk_in),
        .rst_n      (rst_n_in),
        .clr        (start_ok),
        .shift_en   (pk_shift),
        .byte_in    (byte_in),
        .word       (pk_word),
        .word_done  (pk_done)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start_in) state_nxt = HEADER;
            end
            HEADER: begin
                if (pk_done) state_nxt = hdr_bad ? ERROR : PAYLOAD;
            end
            PAYLOAD: begin
                if (pk_done && last_word) state_nxt = CHECK;
            end
            CHECK: begin
                if (xfer) state_nxt = (byte_in == csum) ? DONE : ERROR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_ready_out = 1'b0;
        busy_out       = 1'b0;
        done_out       = 1'b0;
        error_out      = 1'b0;
        cpu_rst_out    = 1'b1;
        case (state)
            HEADER, PAYLOAD, CHECK: begin
                byte_ready_out = 1'b1;
                busy_out       = 1'b1;
            end
            DONE: begin
                done_out    = 1'b1;
                cpu_rst_out = 1'b0;
            end
            ERROR:   error_out = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            n_words      <= '0;
            word_idx     <= '0;
            csum         <= '0;
            mem_we_out   <= 1'b0;
            mem_addr_out <= '0;
            mem_data_out <= '0;
        end else begin
            mem_we_out <= 1'b0;
            if (start_ok) begin
                n_words  <= '0;
                word_idx <= '0;
                csum     <= '0;
            end
            if (state == HEADER && pk_done) begin
                n_words <= pk_word[CNT_W-1:0];
            end
            if (state == PAYLOAD && pk_shift) begin
                csum <= csum + byte_in;
                if (pk_done) begin
                    mem_we_out   <= 1'b1;
                    mem_data_out <= pk_word;
                    mem_addr_out <= ADDR_WIDTH'(word_idx);
                    word_idx     <= word_idx + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomised directed bench for inst_loader with a byte-stream reference model.
module tb_inst_loader;

    localparam int AW   = 12;
    localparam int MAXW = 128;

    typedef logic [7:0] bq_t [$];

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          start_in;
    logic [7:0]    byte_in;
    logic          byte_valid_in;
    logic          byte_ready_out;
    logic [AW-1:0] mem_addr_out;
    logic [31:0]   mem_data_out;
    logic          mem_we_out;
    logic          cpu_rst_out;
    logic          busy_out;
    logic          done_out;
    logic          error_out;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    bit prev_we = 1'b0;

    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic [31:0]   exp_data[$];
    int            m_consumed;
    bit            m_done;
    int            ld_idx, ld_cyc;
    bit            ld_to;

    inst_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .start_in       (start_in),
        .byte_in        (byte_in),
        .byte_valid_in  (byte_valid_in),
        .byte_ready_out (byte_ready_out),
        .mem_addr_out   (mem_addr_out),
        .mem_data_out   (mem_data_out),
        .mem_we_out     (mem_we_out),
        .cpu_rst_out    (cpu_rst_out),
        .busy_out       (busy_out),
        .done_out       (done_out),
        .error_out      (error_out)
    );

    always #5 clk_in = ~clk_in;

    // Write capture plus cycle-by-cycle output invariants, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (mem_we_out === 1'b1) begin
            got_addr.push_back(mem_addr_out);
            got_data.push_back(mem_data_out);
        end
        if (mem_we_out === 1'b1 && prev_we) viol++;
        if (cpu_rst_out !== ~done_out) viol++;
        if (done_out === 1'b1 && error_out === 1'b1) viol++;
        if (busy_out !== byte_ready_out) viol++;
        prev_we = (mem_we_out === 1'b1);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of a stream, derived directly from the framing rules.
    task automatic model(input bq_t b);
        logic [31:0] n;
        logic [7:0]  sum;
        int          nn;
        exp_data.delete();
        n = {b[3], b[2], b[1], b[0]};
        if (n == 32'd0 || n > 32'(MAXW)) begin
            m_consumed = 4;
            m_done     = 1'b0;
            return;
        end
        nn  = int'(n);
        sum = 8'd0;
        for (int w = 0; w < nn; w++) begin
            exp_data.push_back({b[4*w+7], b[4*w+6], b[4*w+5], b[4*w+4]});
            for (int k = 0; k < 4; k++) sum += b[4*w+4+k];
        end
        m_consumed = 4 + 4*nn + 1;
        m_done     = (b[4 + 4*nn] == sum);
    endtask

    function automatic bq_t make_prog(input int n, input bit corrupt);
        bq_t        q;
        logic [7:0] s = 8'd0;
        logic [7:0] r;
        q.push_back(n[7:0]);
        q.push_back(n[15:8]);
        q.push_back(n[23:16]);
        q.push_back(n[31:24]);
        for (int i = 0; i < 4*n; i++) begin
            r = 8'($urandom);
            q.push_back(r);
            s += r;
        end
        q.push_back(corrupt ? s + 8'($urandom_range(1, 255)) : s);
        return q;
    endfunction

    task automatic run_load(input bq_t b, input int prob, input int start_at);
        bit sent = 1'b0;
        got_addr.delete();
        got_data.delete();
        ld_idx = 0;
        ld_cyc = 0;
        ld_to  = 1'b0;
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        while (ld_idx < b.size() && busy_out === 1'b1 && !ld_to) begin
            byte_in       = b[ld_idx];
            byte_valid_in = ($urandom_range(99) < prob);
            start_in      = 1'b0;
            if (!sent && start_at >= 0 && ld_idx >= start_at) begin
                start_in = 1'b1;
                sent     = 1'b1;
            end
            if (byte_valid_in && byte_ready_out === 1'b1) ld_idx++;
            @(negedge clk_in);
            ld_cyc++;
            if (ld_cyc > 20000) ld_to = 1'b1;
        end
        byte_valid_in = 1'b0;
        start_in      = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    task automatic verify(input string tag);
        check({tag, ":timeout"}, ld_to, 0);
        check({tag, ":consumed"}, ld_idx, m_consumed);
        check({tag, ":nwrites"}, got_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            check($sformatf("%s:addr%0d", tag, i), got_addr[i], i);
            check($sformatf("%s:data%0d", tag, i), got_data[i], exp_data[i]);
        end
        check({tag, ":done"}, done_out, m_done);
        check({tag, ":error"}, error_out, !m_done);
        check({tag, ":cpu_rst"}, cpu_rst_out, !m_done);
        check({tag, ":busy"}, busy_out, 0);
        check({tag, ":invariants"}, viol, 0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ":busy"}, busy_out, 0);
        check({tag, ":ready"}, byte_ready_out, 0);
        check({tag, ":we"}, mem_we_out, 0);
        check({tag, ":addr"}, mem_addr_out, 0);
        check({tag, ":data"}, mem_data_out, 0);
        check({tag, ":done"}, done_out, 0);
        check({tag, ":error"}, error_out, 0);
        check({tag, ":cpu_rst"}, cpu_rst_out, 1);
    endtask

    initial begin
        bq_t nominal, b;
        int  n;
        int  nw;

        rst_n_in      = 1'b0;
        start_in      = 1'b0;
        byte_valid_in = 1'b0;
        byte_in       = 8'h00;
        #12;
        check_reset("reset");
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;

        // Bytes offered while idle must be ignored.
        byte_in       = 8'h5A;
        byte_valid_in = 1'b1;
        repeat (5) @(negedge clk_in);
        byte_valid_in = 1'b0;
        check("idle:nwrites", got_data.size(), 0);
        check("idle:busy", busy_out, 0);

        nominal = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                    8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};

        run_load(nominal, 100, -1);
        model(nominal);
        verify("nominal");
        check("nominal:cycles", ld_cyc, 13);
        check("nominal:word0", got_data.size() > 0 ? got_data[0] : 32'hx, 32'h0000_0013);
        check("nominal:word1", got_data.size() > 1 ? got_data[1] : 32'hx, 32'h0010_0093);

        // Stray bytes after DONE: not consumed, no writes, status held.
        nw            = got_data.size();
        byte_valid_in = 1'b1;
        repeat (5) @(negedge clk_in);
        byte_valid_in = 1'b0;
        check("after_done:nwrites", got_data.size(), nw);
        check("after_done:done", done_out, 1);

        b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load(b, 100, -1);
        model(b);
        verify("n0");
        check("n0:cycles", ld_cyc, 4);

        b = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_load(b, 100, -1);
        model(b);
        verify("n129");
        check("n129:cycles", ld_cyc, 4);

        b = nominal;
        b[12] = 8'hB7;
        run_load(b, 100, -1);
        model(b);
        verify("badsum");

        run_load(nominal, 50, -1);
        model(nominal);
        verify("backpressure");

        run_load(nominal, 100, 7);
        model(nominal);
        verify("start_busy");
        check("start_busy:cycles", ld_cyc, 13);

        b = make_prog(MAXW, 1'b0);
        run_load(b, 100, -1);
        model(b);
        verify("n128");

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 10);
            b = make_prog(n, 1'($urandom_range(0, 1)));
            run_load(b, $urandom_range(30, 100), -1);
            model(b);
            verify($sformatf("rand%0d", t));
        end

        // Reset after 4 header + 6 payload bytes.
        got_addr.delete();
        got_data.delete();
        @(negedge clk_in);
        start_in = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            byte_in       = nominal[i];
            byte_valid_in = 1'b1;
            @(negedge clk_in);
        end
        byte_valid_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset("midreset");
        check("midreset:nwrites", got_data.size(), 1);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        for (int i = 10; i < 13; i++) begin
            byte_in       = nominal[i];
            byte_valid_in = 1'b1;
            repeat (3) @(negedge clk_in);
        end
        byte_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("midreset:no_late_write", got_data.size(), 1);
        check("midreset:busy", busy_out, 0);

        run_load(nominal, 100, -1);
        model(nominal);
        verify("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
